reg_block_2r1w: RTL and testbench

- General-purpose register file for the 16-bit datapath.
- Two asynchronous (combinational) read ports and one synchronous write port.
- Sits between instruction decode (which supplies the register addresses) and the ALU/writeback path.
- All registers clear on reset.

---
 rtl/reg_block_2r1w_if.sv | 34 +++
 rtl/reg_block_2r1w.sv | 37 +++
 tb/tb_reg_block_2r1w.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_block_2r1w_if.sv
// rtl/reg_block_2r1w_if.sv - write and dual-read signal bundle for the 2R1W register file
// Decode and writeback connect through the master modport; the register file connects through the slave modport.
interface reg_block_2r1w_if #(
    parameter int n         = 16,
    parameter int addr_size = 3
);
    logic                 We;
    logic [addr_size-1:0] Rw;
    logic [n-1:0]         WData;
    logic [addr_size-1:0] Rs1;
    logic [addr_size-1:0] Rs2;
    logic [n-1:0]         Rd1;
    logic [n-1:0]         Rd2;

    modport master (
        output We,
        output Rw,
        output WData,
        output Rs1,
        output Rs2,
        input  Rd1,
        input  Rd2
    );

    modport slave (
        input  We,
        input  Rw,
        input  WData,
        input  Rs1,
        input  Rs2,
        output Rd1,
        output Rd2
    );
endinterface

// File: rtl/reg_block_2r1w.sv
// rtl/reg_block_2r1w.sv - general-purpose register file, two combinational reads, one clocked write
// Reset clears every register asynchronously; reads have no write bypass.
module reg_block_2r1w #(
    parameter int n         = 16,
    parameter int reg_count = 8,
    parameter int addr_size = 3
) (
    input  logic             Clock,
    input  logic             Reset,
    reg_block_2r1w_if.slave  bus
);
    // One extra bit so an address equal to reg_count compares correctly.
    localparam logic [addr_size:0] reg_lim = reg_count[addr_size:0];

    logic [n-1:0] regs [0:reg_count-1];

    logic wr_hit;
    logic rd1_hit;
    logic rd2_hit;

    assign wr_hit  = bus.We && ({1'b0, bus.Rw} < reg_lim);
    assign rd1_hit = {1'b0, bus.Rs1} < reg_lim;
    assign rd2_hit = {1'b0, bus.Rs2} < reg_lim;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < reg_count; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            regs[bus.Rw] <= bus.WData;
        end
    end

    assign bus.Rd1 = rd1_hit ? regs[bus.Rs1] : '0;
    assign bus.Rd2 = rd2_hit ? regs[bus.Rs2] : '0;
endmodule

// File: tb/tb_reg_block_2r1w.sv
// tb/tb_reg_block_2r1w.sv - directed vector table plus corner sequences for reg_block_2r1w
// Inputs change on the falling edge; outputs are sampled shortly after the rising edge.
module tb_reg_block_2r1w;
    logic Clock;
    logic Reset;

    int n_cmp;
    int n_err;

    logic [15:0] model [0:7];

    reg_block_2r1w_if #(.n(16), .addr_size(3)) bus ();

    reg_block_2r1w #(
        .n         (16),
        .reg_count (8),
        .addr_size (3)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #50 Clock = ~Clock;

    typedef struct {
        logic        we;
        logic [2:0]  rw;
        logic [15:0] wdata;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;

    vec_t vecs [0:6];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s regs[%0d]", name, i), dut.regs[i], 16'h0000);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;

        // We, Rw, WData, Rs1, Rs2, expected Rd1, expected Rd2 after the edge
        vecs[0] = '{1'b1, 3'd5, 16'hA5C3, 3'd5, 3'd5, 16'hA5C3, 16'hA5C3};
        vecs[1] = '{1'b1, 3'd0, 16'h1234, 3'd0, 3'd5, 16'h1234, 16'hA5C3};
        vecs[2] = '{1'b0, 3'd2, 16'hFFFF, 3'd2, 3'd0, 16'h0000, 16'h1234};
        vecs[3] = '{1'b1, 3'd7, 16'h0F0F, 3'd7, 3'd2, 16'h0F0F, 16'h0000};
        vecs[4] = '{1'b1, 3'd5, 16'h5555, 3'd5, 3'd0, 16'h5555, 16'h1234};
        vecs[5] = '{1'b0, 3'd7, 16'hFFFF, 3'd7, 3'd5, 16'h0F0F, 16'h5555};
        vecs[6] = '{1'b1, 3'd3, 16'hFFFF, 3'd3, 3'd3, 16'hFFFF, 16'hFFFF};

        Reset     = 1'b1;
        bus.We    = 1'b0;
        bus.Rw    = 3'd0;
        bus.WData = 16'h0000;
        bus.Rs1   = 3'd3;
        bus.Rs2   = 3'd7;
        @(posedge Clock);
        #1;
        check_all_zero("reset");
        check("reset Rd1", bus.Rd1, 16'h0000);
        check("reset Rd2", bus.Rd2, 16'h0000);
        @(negedge Clock);
        Reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            @(negedge Clock);
            bus.We    = vecs[v].we;
            bus.Rw    = vecs[v].rw;
            bus.WData = vecs[v].wdata;
            bus.Rs1   = vecs[v].rs1;
            bus.Rs2   = vecs[v].rs2;
            @(posedge Clock);
            #1;
            bus.We = 1'b0;
            check($sformatf("vec%0d Rd1", v), bus.Rd1, vecs[v].e1);
            check($sformatf("vec%0d Rd2", v), bus.Rd2, vecs[v].e2);
        end
        check("we0 regs[2]", dut.regs[2], 16'h0000);

        // Address change propagates combinationally, well inside 10 ns.
        @(negedge Clock);
        bus.Rs1 = 3'd0;
        bus.Rs2 = 3'd7;
        #9;
        check("comb Rd1", bus.Rd1, 16'h1234);
        check("comb Rd2", bus.Rd2, 16'h0F0F);

        // Read during write: old value before the edge, new value after.
        @(negedge Clock);
        bus.We    = 1'b1;
        bus.Rw    = 3'd4;
        bus.WData = 16'hBEEF;
        bus.Rs1   = 3'd4;
        bus.Rs2   = 3'd4;
        #49;
        check("rdw before Rd1", bus.Rd1, 16'h0000);
        check("rdw before Rd2", bus.Rd2, 16'h0000);
        @(posedge Clock);
        #1;
        bus.We = 1'b0;
        check("rdw after Rd1", bus.Rd1, 16'hBEEF);
        check("rdw after Rd2", bus.Rd2, 16'hBEEF);

        // Reset dominates a coincident write, then the first edge after release writes.
        @(negedge Clock);
        Reset     = 1'b1;
        bus.We    = 1'b1;
        bus.Rw    = 3'd6;
        bus.WData = 16'hCAFE;
        bus.Rs1   = 3'd6;
        bus.Rs2   = 3'd4;
        @(posedge Clock);
        #1;
        check_all_zero("held reset");
        check("held reset Rd1", bus.Rd1, 16'h0000);
        check("held reset Rd2", bus.Rd2, 16'h0000);
        @(negedge Clock);
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        bus.We = 1'b0;
        check("post reset write Rd1", bus.Rd1, 16'hCAFE);
        check("post reset regs[4]", dut.regs[4], 16'h0000);

        for (int i = 0; i < 8; i++) begin
            model[i] = dut.regs[i];
        end
        model[6] = 16'hCAFE;
        for (int i = 0; i < 8; i++) begin
            if (i != 6) model[i] = 16'h0000;
        end

        for (int it = 0; it < 100; it++) begin
            int a;
            int b;
            logic [15:0] d;
            a = $urandom_range(0, 7);
            b = $urandom_range(0, 7);
            d = 16'($urandom);
            @(negedge Clock);
            bus.We    = 1'b1;
            bus.Rw    = 3'(a);
            bus.WData = d;
            @(posedge Clock);
            #1;
            bus.We   = 1'b0;
            model[a] = d;
            bus.Rs1  = 3'(a);
            bus.Rs2  = 3'(a);
            #4;
            check($sformatf("rand%0d same Rd1", it), bus.Rd1, model[a]);
            check($sformatf("rand%0d same Rd2", it), bus.Rd2, model[a]);
            bus.Rs2 = 3'(b);
            #4;
            check($sformatf("rand%0d other Rd2", it), bus.Rd2, model[b]);

            if (it == 50) begin
                #10;
                Reset = 1'b1;
                #1;
                check_all_zero("async reset");
                check("async reset Rd1", bus.Rd1, 16'h0000);
                check("async reset Rd2", bus.Rd2, 16'h0000);
                #5;
                Reset = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    model[k] = 16'h0000;
                end
            end
        end

        for (int k = 0; k < 8; k++) begin
            check($sformatf("final regs[%0d]", k), dut.regs[k], model[k]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
